router_1xn: RTL and testbench

Parametrised single-input, N-output packet router, successor to the fixed 1x3 router. It accepts byte-serial packets (header, payload, XOR parity) on one input port and steers each packet into a per-channel FIFO selected by the header address. It checks parity and declared length, and discards packets addressed to non-existent channels. It sits between the upstream packet source and N independent downstream readers.

---
 rtl/router_1xn.sv | 228 ++++++++++++++++++++++
 tb/tb_router_1xn.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_1xn.sv
// Parametrised 1xN byte-serial packet router with per-channel first-word-fall-through FIFOs.
// Optional idle-read flush per channel is compiled in with `define ROUTER_SOFT_RESET_EN.
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int CHANNELS   = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         pkt_valid,
  input  logic [DATA_W-1:0]            data_in,
  input  logic [CHANNELS-1:0]          read_enb,
  output logic [CHANNELS*DATA_W-1:0]   data_out,
  output logic [CHANNELS-1:0]          vld_out,
  output logic                         busy,
  output logic                         err,
  output logic [1:0]                   err_type
);

  localparam int ADDR_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int CNT_W  = LEN_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("router_1xn: CHANNELS must be in 2..16");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("router_1xn: FIFO_DEPTH must be a power of two, at least 4");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("router_1xn: TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP, S_CHECK} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_s;
  logic [DATA_W-1:0]   par_q, par_d;
  logic                bad_q, bad_d;
  logic                err_q, err_d;
  logic [1:0]          err_type_q, err_type_d;

  logic [ADDR_W-1:0]   hdr_addr_s;
  logic [LEN_W-1:0]    hdr_len_s;
  logic                hdr_ok_s, hdr_full_s, hdr_flush_s;
  logic                cur_full_s, cur_flush_s;
  logic                len_bad_s, par_bad_s, finish_s, busy_s;
  logic [CHANNELS-1:0] full_s, flush_s, wr_en_s;

  function automatic logic [CHANNELS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [CHANNELS-1:0] v;
    v = '0;
    for (int k = 0; k < CHANNELS; k++) v[k] = (a == ADDR_W'(k));
    return v;
  endfunction

  assign hdr_addr_s  = data_in[ADDR_W-1:0];
  assign hdr_len_s   = data_in[DATA_W-1:ADDR_W];
  assign hdr_ok_s    = ({{(32-ADDR_W){1'b0}}, hdr_addr_s} < 32'(CHANNELS));
  assign hdr_full_s  = |(full_s  & onehot(hdr_addr_s));
  assign hdr_flush_s = |(flush_s & onehot(hdr_addr_s));
  assign cur_full_s  = |(full_s  & onehot(addr_q));
  assign cur_flush_s = |(flush_s & onehot(addr_q));
  // Payload count saturates so oversize packets still read as a length mismatch.
  assign cnt_inc_s   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign len_bad_s   = (cnt_q != {1'b0, len_q});
  assign par_bad_s   = (par_q != data_in);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    bad_d      = bad_q;
    err_d      = 1'b0;
    err_type_d = err_type_q;
    wr_en_s    = '0;
    busy_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!pkt_valid) begin
          state_d = S_IDLE;
        end else if (!hdr_ok_s) begin
          bad_d   = 1'b1;
          state_d = S_DROP;
        end else if (hdr_full_s) begin
          busy_s  = 1'b1;
        end else begin
          wr_en_s = onehot(hdr_addr_s);
          addr_d  = hdr_addr_s;
          len_d   = hdr_len_s;
          cnt_d   = '0;
          par_d   = data_in;
          bad_d   = 1'b0;
          state_d = hdr_flush_s ? S_DROP : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        busy_s = cur_full_s;
        if (cur_full_s) begin
          state_d = S_PAYLOAD;
        end else if (pkt_valid) begin
          wr_en_s = onehot(addr_q);
          par_d   = par_q ^ data_in;
          cnt_d   = cnt_inc_s;
          state_d = cur_flush_s ? S_DROP : S_PAYLOAD;
        end else begin
          wr_en_s  = onehot(addr_q);
          finish_s = 1'b1;
        end
      end
      // A flushed packet keeps its parity/length bookkeeping so CHECK reports as usual.
      S_DROP: begin
        if (!pkt_valid) begin
          finish_s = 1'b1;
        end else if (!bad_q) begin
          par_d = par_q ^ data_in;
          cnt_d = cnt_inc_s;
        end else begin
          state_d = S_DROP;
        end
      end
      S_CHECK: begin
        busy_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish_s) begin
      state_d    = S_CHECK;
      err_d      = bad_q | len_bad_s | par_bad_s;
      err_type_d = bad_q ? 2'b11 : len_bad_s ? 2'b10 : par_bad_s ? 2'b01 : err_type_q;
    end else begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      par_q      <= '0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
      err_type_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      err_type_q <= err_type_d;
    end
  end

  assign busy     = busy_s;
  assign err      = err_q;
  assign err_type = err_type_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wp_q, rp_q;
    logic [OCC_W-1:0]  occ_q;
    logic              vld_s, push_s, pop_s;

    assign vld_s     = (occ_q != '0);
    assign full_s[k] = (occ_q == OCC_W'(FIFO_DEPTH));
    assign push_s    = wr_en_s[k] & ~full_s[k] & ~flush_s[k];
    assign pop_s     = read_enb[k] & vld_s;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wp_q  <= '0;
        rp_q  <= '0;
        occ_q <= '0;
      end else if (flush_s[k]) begin
        wp_q  <= '0;
        rp_q  <= '0;
        occ_q <= '0;
      end else begin
        wp_q  <= push_s ? wp_q + PTR_W'(1) : wp_q;
        rp_q  <= pop_s  ? rp_q + PTR_W'(1) : rp_q;
        occ_q <= occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
      end
    end

    always_ff @(posedge clock) begin
      if (push_s) mem_q[wp_q] <= data_in;
    end

    assign vld_out[k]                    = vld_s;
    assign data_out[k*DATA_W +: DATA_W]  = vld_s ? mem_q[rp_q] : '0;

`ifdef ROUTER_SOFT_RESET_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_q;
    logic            stall_s;

    assign stall_s    = vld_s & ~read_enb[k];
    assign flush_s[k] = stall_s & (idle_q == TO_W'(TIMEOUT - 1));

    // Counts consecutive cycles the head entry waits unread.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        idle_q <= '0;
      end else if (stall_s & ~flush_s[k]) begin
        idle_q <= idle_q + TO_W'(1);
      end else begin
        idle_q <= '0;
      end
    end
`else
    assign flush_s[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_router_1xn.sv
// Scoreboard bench for router_1xn: per-channel byte queues and an error-type queue
// are filled as stimulus is accepted and drained as the DUT pops or flags errors.
module tb_router_1xn;

  localparam int CH    = 3;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 16;
  localparam int TMO   = 30;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              pkt_valid = 1'b0;
  logic [DW-1:0]     data_in = '0;
  logic [CH-1:0]     read_enb;
  logic [CH*DW-1:0]  data_out;
  logic [CH-1:0]     vld_out;
  logic              busy;
  logic              err;
  logic [1:0]        err_type;

  logic [CH-1:0]     rd_mask = '0;
  bit                mon_en = 1'b0;
  int                vectors = 0;
  int                miscompares = 0;
  logic [7:0]        sb [CH][$];
  logic [1:0]        eq [$];
  int                idle_m [CH];

  router_1xn #(.DATA_W(DW), .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out), .busy(busy),
    .err(err), .err_type(err_type)
  );

  always #5 clock = ~clock;

  // Monitor: read_enb driven from rd_mask; pops, vld_out and err checked against the model.
  initial begin
    read_enb = '0;
    for (int k = 0; k < CH; k++) idle_m[k] = 0;
    forever begin
      @(negedge clock);
      read_enb = rd_mask;
      #1;
      if (mon_en && resetn) begin
        for (int k = 0; k < CH; k++) begin
          vectors++;
          if (vld_out[k] !== (sb[k].size() != 0)) begin
            miscompares++;
            $display("FAIL vld_out[%0d]: got %b, want %b", k, vld_out[k], sb[k].size() != 0);
          end
          if (vld_out[k] === 1'b1 && read_enb[k] && sb[k].size() > 0) begin
            vectors++;
            if (data_out[k*DW +: DW] !== sb[k][0]) begin
              miscompares++;
              $display("FAIL data_out[%0d]: got %h, want %h", k, data_out[k*DW +: DW], sb[k][0]);
            end
            void'(sb[k].pop_front());
          end else if (vld_out[k] !== 1'b1) begin
            vectors++;
            if (data_out[k*DW +: DW] !== 8'h00) begin
              miscompares++;
              $display("FAIL data_out_empty[%0d]: got %h, want 00", k, data_out[k*DW +: DW]);
            end
          end
`ifdef ROUTER_SOFT_RESET_EN
          if (sb[k].size() != 0 && !read_enb[k]) begin
            idle_m[k]++;
            if (idle_m[k] == TMO) begin
              sb[k].delete();
              idle_m[k] = 0;
            end
          end else begin
            idle_m[k] = 0;
          end
`endif
        end
        if (err !== 1'b0) begin
          vectors++;
          if (eq.size() == 0) begin
            miscompares++;
            $display("FAIL err_unexpected: got err=%b type=%b, want no error", err, err_type);
          end else begin
            if (err_type !== eq[0]) begin
              miscompares++;
              $display("FAIL err_type: got %b, want %b", err_type, eq[0]);
            end
            void'(eq.pop_front());
          end
        end
      end
    end
  end

  task automatic send_byte(input logic v, input logic [7:0] d, input int ch, output int waits);
    waits = 0;
    forever begin
      @(negedge clock);
      pkt_valid = v;
      data_in   = d;
      #2;
      if (busy === 1'b0) break;
      waits++;
      if (waits > 300) begin
        miscompares++;
        $display("FAIL busy_timeout: got busy=%b for %0d cycles, want 0", busy, waits);
        return;
      end
    end
    if (ch >= 0) sb[ch].push_back(d);
  endtask

  task automatic send_pkt(input int addr, input int len, input int npay, input bit bad_par,
                          output int hdr_w, output int tot_w);
    logic [7:0] h, b, p;
    int w, ch;
    ch = (addr < CH) ? addr : -1;
    h = 8'((len << AW) | addr);
    p = h;
    send_byte(1'b1, h, ch, w);
    hdr_w = w;
    tot_w = w;
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom_range(0, 255));
      p = p ^ b;
      send_byte(1'b1, b, ch, w);
      tot_w += w;
    end
    if (bad_par) p = ~p;
    send_byte(1'b0, p, ch, w);
    tot_w += w;
    if (ch < 0)              eq.push_back(2'b11);
    else if (npay != len)    eq.push_back(2'b10);
    else if (bad_par)        eq.push_back(2'b01);
  endtask

  task automatic wait_drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 400 && !empty; i++) begin
      @(negedge clock);
      #3;
      empty = (eq.size() == 0);
      for (int k = 0; k < CH; k++) if (sb[k].size() != 0) empty = 1'b0;
    end
    @(negedge clock);
    #3;
    vectors++;
    if (!empty) begin
      miscompares++;
      $display("FAIL drain: got outstanding bytes/errors after timeout, want none");
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    vectors += 5;
    if (vld_out !== '0)   begin miscompares++; $display("FAIL reset_vld: got %b, want 000", vld_out); end
    if (data_out !== '0)  begin miscompares++; $display("FAIL reset_data: got %h, want 0", data_out); end
    if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b, want 0", busy); end
    if (err !== 1'b0)     begin miscompares++; $display("FAIL reset_err: got %b, want 0", err); end
    if (err_type !== 2'b00) begin miscompares++; $display("FAIL reset_err_type: got %b, want 00", err_type); end
    @(negedge clock);
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int hw, tw;
    rd_mask = '0;
    send_pkt(0, 14, 14, 1'b0, hw, tw);
    repeat (2) @(posedge clock);
    #1 rd_mask = 3'b001;
    wait_drain();
    vectors++;
    if (vld_out[0] !== 1'b0) begin miscompares++; $display("FAIL basic_vld_fall: got %b, want 0", vld_out[0]); end
  endtask

  task automatic test_parity();
    int hw, tw;
    rd_mask = 3'b010;
    send_pkt(1, 16, 16, 1'b1, hw, tw);
    wait_drain();
  endtask

  task automatic test_length();
    int hw, tw;
    rd_mask = 3'b100;
    send_pkt(2, 5, 7, 1'b0, hw, tw);
    wait_drain();
  endtask

  task automatic test_bad_addr();
    int hw, tw;
    rd_mask = 3'b111;
    send_pkt(3, 2, 2, 1'b0, hw, tw);
    vectors++;
    if (tw !== 0) begin miscompares++; $display("FAIL bad_addr_busy: got %0d busy cycles, want 0", tw); end
    wait_drain();
    vectors++;
    if (err_type !== 2'b11) begin miscompares++; $display("FAIL bad_addr_hold: got %b, want 11", err_type); end
  endtask

  task automatic test_full();
    logic [7:0] h, b, p;
    int w, w16, w17, acc;
    rd_mask = '0;
    h = 8'((20 << AW) | 0);
    p = h;
    send_byte(1'b1, h, 0, w);
    acc = w;
    for (int i = 1; i < 16; i++) begin
      b = 8'(i * 7 + 3); p = p ^ b;
      send_byte(1'b1, b, 0, w);
      acc += w;
    end
    vectors++;
    if (acc !== 0) begin miscompares++; $display("FAIL full_first16: got %0d busy cycles, want 0", acc); end
    b = 8'hA5; p = p ^ b;
    fork
      send_byte(1'b1, b, 0, w16);
      begin
        repeat (3) @(posedge clock);
        #1 rd_mask[0] = 1'b1;
        @(posedge clock);
        #1 rd_mask[0] = 1'b0;
      end
    join
    vectors++;
    if (w16 == 0) begin miscompares++; $display("FAIL full_busy_rise: got %0d busy cycles, want >0", w16); end
    b = 8'h5A; p = p ^ b;
    fork
      send_byte(1'b1, b, 0, w17);
      begin
        repeat (4) @(posedge clock);
        #1 rd_mask[0] = 1'b1;
      end
    join
    vectors++;
    if (w17 == 0) begin miscompares++; $display("FAIL full_one_more: got %0d busy cycles, want >0", w17); end
    for (int i = 18; i < 21; i++) begin
      b = 8'(i * 11); p = p ^ b;
      send_byte(1'b1, b, 0, w);
    end
    send_byte(1'b0, p, 0, w);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int hw, tw;
    rd_mask = 3'b111;
    send_pkt(0, 3, 3, 1'b0, hw, tw);
    send_pkt(1, 0, 0, 1'b0, hw, tw);
    vectors++;
    if (hw !== 1) begin miscompares++; $display("FAIL b2b_len0_hdr: got %0d wait cycles, want 1", hw); end
    send_pkt(2, 2, 2, 1'b1, hw, tw);
    vectors++;
    if (hw !== 1) begin miscompares++; $display("FAIL b2b_hdr: got %0d wait cycles, want 1", hw); end
    wait_drain();
    vectors++;
    if (err_type !== 2'b01) begin miscompares++; $display("FAIL b2b_err_type: got %b, want 01", err_type); end
  endtask

  task automatic test_reset_mid();
    int w, hw, tw;
    rd_mask = '0;
    send_byte(1'b1, 8'((5 << AW) | 1), 1, w);
    send_byte(1'b1, 8'h11, 1, w);
    send_byte(1'b1, 8'h22, 1, w);
    @(negedge clock);
    mon_en = 1'b0;
    pkt_valid = 1'b0;
    resetn = 1'b0;
    #1;
    vectors += 3;
    if (vld_out !== '0)   begin miscompares++; $display("FAIL mid_reset_vld: got %b, want 000", vld_out); end
    if (busy !== 1'b0)    begin miscompares++; $display("FAIL mid_reset_busy: got %b, want 0", busy); end
    if (err_type !== 2'b00) begin miscompares++; $display("FAIL mid_reset_err_type: got %b, want 00", err_type); end
    for (int k = 0; k < CH; k++) begin sb[k].delete(); idle_m[k] = 0; end
    eq.delete();
    @(negedge clock);
    resetn = 1'b1;
    mon_en = 1'b1;
    rd_mask = 3'b010;
    send_pkt(1, 2, 2, 1'b0, hw, tw);
    wait_drain();
  endtask

`ifdef ROUTER_SOFT_RESET_EN
  task automatic test_soft_reset();
    int hw, tw, hi;
    bit seen;
    rd_mask = '0;
    hi = 0;
    seen = 1'b0;
    fork
      send_pkt(2, 2, 2, 1'b0, hw, tw);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clock);
          #3;
          if (vld_out[2] === 1'b1) begin seen = 1'b1; hi++; end
          else if (seen) break;
        end
      end
    join
    vectors++;
    if (hi !== TMO) begin miscompares++; $display("FAIL soft_reset_time: got %0d cycles valid, want %0d", hi, TMO); end
    rd_mask = 3'b100;
    send_pkt(2, 3, 3, 1'b0, hw, tw);
    wait_drain();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_length();
    test_bad_addr();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef ROUTER_SOFT_RESET_EN
    test_soft_reset();
`endif
    vectors++;
    if (eq.size() !== 0) begin miscompares++; $display("FAIL err_missing: got %0d pending errors, want 0", eq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
